// File: rtl/shift_seq_ctrl.sv
// Sequencer for the 8-bit shift_reg datapath: loads a byte and streams it out LSB-first
// with a generated serial clock, holding shift_reg contents via p_in feedback between shifts.
module shift_seq_ctrl #(
    parameter int unsigned DIV  = 4,
    parameter logic        FILL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       sdat,
    output logic       sr_S_L,
    output logic       sr_s_in,
    output logic [7:0] sr_p_in,
    input  logic [7:0] sr_q
);
    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic [DW-1:0] r_divcnt, w_divcnt_nxt;
    logic [2:0]    r_bitcnt, w_bitcnt_nxt;
    logic          r_phase, w_phase_nxt;
    logic [7:0]    r_data_lat, w_data_lat_nxt;
    logic          w_div_end;

    assign w_div_end = (r_divcnt == DW'(DIV - 1));
    assign sr_s_in   = FILL;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_divcnt   <= '0;
            r_bitcnt   <= '0;
            r_phase    <= 1'b0;
            r_data_lat <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_divcnt   <= w_divcnt_nxt;
            r_bitcnt   <= w_bitcnt_nxt;
            r_phase    <= w_phase_nxt;
            r_data_lat <= w_data_lat_nxt;
        end
    end

    // Outputs depend on registered state and sr_q only; start never reaches them combinationally.
    always_comb begin
        w_state_nxt    = r_state;
        w_divcnt_nxt   = r_divcnt;
        w_bitcnt_nxt   = r_bitcnt;
        w_phase_nxt    = r_phase;
        w_data_lat_nxt = r_data_lat;
        sr_S_L         = 1'b0;
        sr_p_in        = sr_q;
        busy           = 1'b0;
        done           = 1'b0;
        sclk           = 1'b0;
        sdat           = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_data_lat_nxt = data_in;
                    w_state_nxt    = S_LOAD;
                end
            end
            S_LOAD: begin
                busy         = 1'b1;
                sr_p_in      = r_data_lat;
                w_divcnt_nxt = '0;
                w_bitcnt_nxt = '0;
                w_phase_nxt  = 1'b0;
                w_state_nxt  = S_SEND;
            end
            S_SEND: begin
                busy         = 1'b1;
                sclk         = r_phase;
                sdat         = sr_q[0];
                w_divcnt_nxt = r_divcnt + 1'b1;
                if (w_div_end) begin
                    w_divcnt_nxt = '0;
                    w_phase_nxt  = ~r_phase;
                    // Last high cycle of the bit: shift once so sdat moves with sclk's fall.
                    if (r_phase) begin
                        sr_S_L       = 1'b1;
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7)
                            w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: two instances (DIV=2/FILL=0, DIV=1/FILL=1) each driving a
// behavioural shift_reg, checked cycle by cycle against a frame-position reference model.
module tb_shift_seq_ctrl;
    localparam int NI = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [7:0]           data_in;
    logic [NI-1:0]        busy, done, sclk, sdat, sl, sin;
    logic [NI-1:0][7:0]   pin;
    logic [NI-1:0][7:0]   q = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic int divof(input int g);
        return (g == 0) ? 2 : 1;
    endfunction

    function automatic logic fillof(input int g);
        return (g == 0) ? 1'b0 : 1'b1;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        shift_seq_ctrl #(
            .DIV  ((g == 0) ? 2 : 1),
            .FILL ((g == 0) ? 1'b0 : 1'b1)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start),
            .data_in (data_in),
            .busy    (busy[g]),
            .done    (done[g]),
            .sclk    (sclk[g]),
            .sdat    (sdat[g]),
            .sr_S_L  (sl[g]),
            .sr_s_in (sin[g]),
            .sr_p_in (pin[g]),
            .sr_q    (q[g])
        );
    end

    // shift_reg behaviour: no enable, no reset
    always @(posedge clk)
        for (int g = 0; g < NI; g++)
            q[g] <= sl[g] ? {sin[g], q[g][7:1]} : pin[g];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: m_pos = -1 idle, 0 load, 1..16*D send, 16*D+1 done.
    int         m_pos [NI] = '{-1, -1};
    logic [7:0] m_byte [NI];
    logic [7:0] cap [NI];
    int         ncap [NI] = '{0, 0};
    int         blen [NI] = '{0, 0};
    logic       psclk [NI] = '{1'b0, 1'b0};
    int         nfr [NI] = '{0, 0};

    always @(negedge clk) begin
        int d, k, b, h;
        logic [7:0] e_q;
        for (int g = 0; g < NI; g++) begin
            d = divof(g);
            if (rst) begin
                m_pos[g] = -1;
                blen[g]  = 0;
                psclk[g] = 1'b0;
            end else begin
                if (m_pos[g] < 0) begin
                    chk("idle_busy", 32'(busy[g]), 0);
                    chk("idle_done", 32'(done[g]), 0);
                    chk("idle_sclk", 32'(sclk[g]), 0);
                    chk("idle_sdat", 32'(sdat[g]), 1);
                    chk("idle_sl",   32'(sl[g]), 0);
                    chk("idle_pin",  32'(pin[g]), 32'(q[g]));
                end else if (m_pos[g] == 0) begin
                    chk("load_busy", 32'(busy[g]), 1);
                    chk("load_done", 32'(done[g]), 0);
                    chk("load_sl",   32'(sl[g]), 0);
                    chk("load_pin",  32'(pin[g]), 32'(m_byte[g]));
                    ncap[g] = 0;
                end else if (m_pos[g] <= 16 * d) begin
                    k   = m_pos[g] - 1;
                    b   = k / (2 * d);
                    h   = k % (2 * d);
                    e_q = m_byte[g] >> b;
                    if (fillof(g)) e_q = e_q | ~(8'hFF >> b);
                    chk("send_busy", 32'(busy[g]), 1);
                    chk("send_done", 32'(done[g]), 0);
                    chk("send_sclk", 32'(sclk[g]), 32'(h >= d));
                    chk("send_sdat", 32'(sdat[g]), 32'(m_byte[g][b]));
                    chk("send_sl",   32'(sl[g]), 32'(h == 2 * d - 1));
                    chk("send_q",    32'(q[g]), 32'(e_q));
                    if (h != 2 * d - 1) chk("send_pin", 32'(pin[g]), 32'(q[g]));
                    if (sclk[g] && !psclk[g]) begin
                        cap[g] = {sdat[g], cap[g][7:1]};
                        ncap[g]++;
                    end
                end else begin
                    chk("done_busy", 32'(busy[g]), 1);
                    chk("done_done", 32'(done[g]), 1);
                    chk("done_sclk", 32'(sclk[g]), 0);
                    chk("done_sdat", 32'(sdat[g]), 1);
                    chk("done_sl",   32'(sl[g]), 0);
                    chk("done_q",    32'(q[g]), fillof(g) ? 32'hFF : 32'h00);
                    chk("done_pin",  32'(pin[g]), 32'(q[g]));
                    chk("bits",      32'(cap[g]), 32'(m_byte[g]));
                    chk("edges",     32'(ncap[g]), 8);
                    nfr[g]++;
                end
                if (busy[g]) blen[g]++;
                else if (blen[g] != 0) begin
                    chk("busy_len", 32'(blen[g]), 32'(16 * d + 2));
                    blen[g] = 0;
                end
                psclk[g] = sclk[g];
                if (m_pos[g] < 0) begin
                    if (start) begin
                        m_pos[g]  = 0;
                        m_byte[g] = data_in;
                    end
                end else if (m_pos[g] == 16 * d + 1) m_pos[g] = -1;
                else m_pos[g]++;
            end
        end
    end

    task automatic drive(input logic s, input logic [7:0] dv, input int n);
        repeat (n) begin
            @(posedge clk);
            #1 start = s;
            data_in = dv;
        end
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; data_in = 8'h00;
        #2;
        chk("rst0_busy", 32'(busy), 0);
        chk("rst0_done", 32'(done), 0);
        chk("rst0_sclk", 32'(sclk), 0);
        chk("rst0_sdat", 32'(sdat), 3);
        chk("rst0_sl",   32'(sl), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        drive(1'b1, 8'hA5, 1);
        drive(1'b0, 8'($urandom), 40);

        drive(1'b1, 8'hF0, 1);
        drive(1'b0, 8'($urandom), 5);
        drive(1'b1, 8'h3C, 6);
        drive(1'b0, 8'($urandom), 40);

        drive(1'b1, 8'h81, 110);
        drive(1'b0, 8'h00, 40);

        // abort 8'hFF during bit 3 of the DIV=2 instance
        drive(1'b1, 8'hFF, 1);
        drive(1'b0, 8'h00, 13);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_sclk", 32'(sclk), 0);
        chk("arst_sdat", 32'(sdat), 3);
        chk("arst_q0",   32'(q[0]), 32'h1F);
        chk("arst_q1",   32'(q[1]), 32'hFF);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_q0", 32'(q[0]), 32'h1F);
        rst = 1'b0;
        drive(1'b1, 8'hFF, 1);
        drive(1'b0, 8'h00, 40);

        drive(1'b1, 8'h00, 1);
        drive(1'b0, 8'h00, 40);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 399) == 0) pulse_rst();
            else drive($urandom_range(0, 7) == 0, 8'($urandom), 1);
        end
        drive(1'b0, 8'h00, 40);

        chk("frames_d2", 32'(nfr[0] >= 20), 1);
        chk("frames_d1", 32'(nfr[1] >= 20), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
